// File: rtl/fft256_pkg.sv
// Shared definitions for the 256-point radix-2^2 SDF FFT pipeline: sizes,
// default widths, W64 coefficient generation and round/saturate helper.
package fft256_pkg;
    localparam int FFT_N    = 256;
    localparam int SUB_N    = 64;
    localparam int DATA_W_DEF = 16;
    localparam int TW_W_DEF   = 16;
    localparam real PI = 3.14159265358979323846;

    function automatic int round_real(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic real frac_scale(input int frac_bits);
        real s;
        s = 1.0;
        for (int i = 0; i < frac_bits; i++) s = s * 2.0;
        return s;
    endfunction

    // Real part of W64^e, scaled so that 1.0 = 2^frac_bits.
    function automatic int w64_cos(input int e, input int frac_bits);
        return round_real($cos(2.0 * PI * $itor(e) / $itor(SUB_N)) * frac_scale(frac_bits));
    endfunction

    // Imaginary part of W64^e (the negative sine).
    function automatic int w64_msin(input int e, input int frac_bits);
        return round_real(-$sin(2.0 * PI * $itor(e) / $itor(SUB_N)) * frac_scale(frac_bits));
    endfunction

    // Round half up, arithmetic shift by frac_bits, clamp to a signed out_w range.
    function automatic logic signed [63:0] round_sat(input logic signed [63:0] acc,
                                                     input int frac_bits,
                                                     input int out_w);
        logic signed [63:0] r;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        r  = (acc + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (r > hi) return hi;
        if (r < lo) return lo;
        return r;
    endfunction
endpackage

// File: rtl/twiddle_rom64.sv
// Combinational W64 twiddle lookup: exponent e[5:0] -> (cos, -sin) coefficients.
module twiddle_rom64
    import fft256_pkg::*;
#(
    parameter int TW_WIDTH = TW_W_DEF
) (
    input  logic [5:0]                 e,
    output logic signed [TW_WIDTH-1:0] c,
    output logic signed [TW_WIDTH-1:0] d
);
    logic signed [TW_WIDTH-1:0] c_tab [SUB_N];
    logic signed [TW_WIDTH-1:0] d_tab [SUB_N];

    // Table contents are elaboration-time constants; only the mux is hardware.
    for (genvar i = 0; i < SUB_N; i++) begin : g_tab
        localparam int C_VAL = w64_cos(i, TW_WIDTH - 2);
        localparam int D_VAL = w64_msin(i, TW_WIDTH - 2);
        assign c_tab[i] = TW_WIDTH'(C_VAL);
        assign d_tab[i] = TW_WIDTH'(D_VAL);
    end

    assign c = c_tab[e];
    assign d = d_tab[e];
endmodule

// File: rtl/fft256_twiddle_mul64.sv
// W64 twiddle multiplier between the delay-16 and delay-8 butterfly stages.
// Three register stages: capture/exponent, products, combine/round/saturate.
module fft256_twiddle_mul64
    import fft256_pkg::*;
#(
    parameter int WIDTH    = DATA_W_DEF,
    parameter int TW_WIDTH = TW_W_DEF
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    di_en,
    input  logic signed [WIDTH-1:0] di_re,
    input  logic signed [WIDTH-1:0] di_im,
    output logic                    do_en,
    output logic signed [WIDTH-1:0] do_re,
    output logic signed [WIDTH-1:0] do_im
);
    localparam int CNT_W  = $clog2(FFT_N);
    localparam int PROD_W = WIDTH + TW_WIDTH;
    localparam int ACC_W  = PROD_W + 1;
    localparam int FRAC   = TW_WIDTH - 2;

    logic [CNT_W-1:0]         cnt_q, cnt_d;
    logic [3:0]               m;
    logic [1:0]               k;

    logic                     vld_p1_q, vld_p1_d;
    logic signed [WIDTH-1:0]  a_p1_q, a_p1_d, b_p1_q, b_p1_d;
    logic [5:0]               e_p1_q, e_p1_d;
    logic signed [TW_WIDTH-1:0] coef_c, coef_d;

    logic                     vld_p2_q, vld_p2_d;
    logic                     byp_p2_q, byp_p2_d;
    logic signed [WIDTH-1:0]  a_p2_q, a_p2_d, b_p2_q, b_p2_d;
    logic signed [PROD_W-1:0] ac_p2_q, ac_p2_d, bd_p2_q, bd_p2_d;
    logic signed [PROD_W-1:0] ad_p2_q, ad_p2_d, bc_p2_q, bc_p2_d;

    logic signed [ACC_W-1:0]  re_acc, im_acc;
    logic                     do_en_q, do_en_d;
    logic signed [WIDTH-1:0]  do_re_q, do_re_d, do_im_q, do_im_d;

    twiddle_rom64 #(.TW_WIDTH(TW_WIDTH)) u_rom (
        .e (e_p1_q),
        .c (coef_c),
        .d (coef_d)
    );

    always_comb begin
        // Sample index: any gap in di_en restarts the frame at 0.
        cnt_d    = di_en ? cnt_q + CNT_W'(1) : '0;
        m        = cnt_q[3:0];
        k        = {cnt_q[4], cnt_q[5]};

        // S1: capture sample and its exponent
        vld_p1_d = di_en;
        a_p1_d   = di_re;
        b_p1_d   = di_im;
        e_p1_d   = 6'(m) * 6'(k);

        // S2: full-precision partial products
        vld_p2_d = vld_p1_q;
        byp_p2_d = (e_p1_q == 6'd0);
        a_p2_d   = a_p1_q;
        b_p2_d   = b_p1_q;
        ac_p2_d  = PROD_W'(a_p1_q) * PROD_W'(coef_c);
        bd_p2_d  = PROD_W'(b_p1_q) * PROD_W'(coef_d);
        ad_p2_d  = PROD_W'(a_p1_q) * PROD_W'(coef_d);
        bc_p2_d  = PROD_W'(b_p1_q) * PROD_W'(coef_c);

        // S3: combine, round, saturate; e=0 passes the sample through exactly
        re_acc   = ACC_W'(ac_p2_q) - ACC_W'(bd_p2_q);
        im_acc   = ACC_W'(ad_p2_q) + ACC_W'(bc_p2_q);
        do_en_d  = vld_p2_q;
        do_re_d  = '0;
        do_im_d  = '0;
        if (vld_p2_q) begin
            if (byp_p2_q) begin
                do_re_d = a_p2_q;
                do_im_d = b_p2_q;
            end else begin
                do_re_d = WIDTH'(round_sat(64'(re_acc), FRAC, WIDTH));
                do_im_d = WIDTH'(round_sat(64'(im_acc), FRAC, WIDTH));
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q    <= '0;
            vld_p1_q <= 1'b0;
            vld_p2_q <= 1'b0;
            do_en_q  <= 1'b0;
            do_re_q  <= '0;
            do_im_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            vld_p1_q <= vld_p1_d;
            vld_p2_q <= vld_p2_d;
            do_en_q  <= do_en_d;
            do_re_q  <= do_re_d;
            do_im_q  <= do_im_d;
        end
    end

    // Data path registers carry no reset; the valid bits qualify them.
    always_ff @(posedge clock) begin
        a_p1_q   <= a_p1_d;
        b_p1_q   <= b_p1_d;
        e_p1_q   <= e_p1_d;
        byp_p2_q <= byp_p2_d;
        a_p2_q   <= a_p2_d;
        b_p2_q   <= b_p2_d;
        ac_p2_q  <= ac_p2_d;
        bd_p2_q  <= bd_p2_d;
        ad_p2_q  <= ad_p2_d;
        bc_p2_q  <= bc_p2_d;
    end

    assign do_en = do_en_q;
    assign do_re = do_re_q;
    assign do_im = do_im_q;
endmodule

// File: tb/tb_fft256_twiddle_mul64.sv
// Self-checking bench for fft256_twiddle_mul64: random streams against a
// complex-rotation reference model plus fixed twiddle/saturation/reset cases.
module tb_fft256_twiddle_mul64;
    localparam int WIDTH    = 16;
    localparam int TW_WIDTH = 16;

    logic                    clock = 1'b0;
    logic                    reset;
    logic                    di_en;
    logic signed [WIDTH-1:0] di_re, di_im;
    logic                    do_en;
    logic signed [WIDTH-1:0] do_re, do_im;

    int checks   = 0;
    int failures = 0;
    int q_en[$];
    int q_re[$];
    int q_im[$];
    int m_cnt;
    int ex_en, ex_re, ex_im;

    always #5 clock = ~clock;

    fft256_twiddle_mul64 #(.WIDTH(WIDTH), .TW_WIDTH(TW_WIDTH)) dut (
        .clock (clock),
        .reset (reset),
        .di_en (di_en),
        .di_re (di_re),
        .di_im (di_im),
        .do_en (do_en),
        .do_re (do_re),
        .do_im (do_im)
    );

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(-x + 0.5);
    endfunction

    function automatic int clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return int'(v);
    endfunction

    function automatic int rand16();
        logic signed [15:0] v;
        v = 16'($urandom);
        return int'(v);
    endfunction

    // Reference: multiply (a + jb) by the quantised exp(-j*2*pi*e/64).
    function automatic void model(input int cnt, input int a, input int b,
                                  output int re, output int im);
        int     e;
        real    th;
        longint c, d, r, i;
        e = (cnt % 16) * (((cnt / 16) % 2) * 2 + ((cnt / 32) % 2));
        if (e == 0) begin
            re = a;
            im = b;
            return;
        end
        th = 2.0 * 3.14159265358979 * $itor(e) / 64.0;
        c  = longint'(rnd($cos(th) * 16384.0));
        d  = longint'(rnd(-$sin(th) * 16384.0));
        r  = (longint'(a) * c - longint'(b) * d + 64'sd8192) >>> 14;
        i  = (longint'(a) * d + longint'(b) * c + 64'sd8192) >>> 14;
        re = clamp16(r);
        im = clamp16(i);
    endfunction

    task automatic reset_model();
        q_en.delete(); q_re.delete(); q_im.delete();
        repeat (2) begin
            q_en.push_back(0); q_re.push_back(0); q_im.push_back(0);
        end
        m_cnt = 0;
    endtask

    // Drive one input sample, advance one clock and expose the expected output.
    task automatic cycle(input bit en, input int a, input int b);
        int r, i;
        di_en = en;
        di_re = WIDTH'(a);
        di_im = WIDTH'(b);
        if (en) begin
            model(m_cnt, a, b, r, i);
            q_en.push_back(1); q_re.push_back(r); q_im.push_back(i);
            m_cnt = (m_cnt + 1) % 256;
        end else begin
            q_en.push_back(0); q_re.push_back(0); q_im.push_back(0);
            m_cnt = 0;
        end
        @(posedge clock);
        #1;
        ex_en = q_en.pop_front();
        ex_re = q_re.pop_front();
        ex_im = q_im.pop_front();
    endtask

    task automatic test_reset();
        reset = 1'b1; di_en = 1'b0; di_re = '0; di_im = '0;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (do_en !== 1'b0) begin failures++; $display("FAIL reset_do_en got=%b want=0", do_en); end
        checks++;
        if (do_re !== 16'sd0) begin failures++; $display("FAIL reset_do_re got=%0d want=0", do_re); end
        checks++;
        if (do_im !== 16'sd0) begin failures++; $display("FAIL reset_do_im got=%0d want=0", do_im); end
        reset = 1'b0;
        reset_model();
    endtask

    task automatic test_bypass_frame();
        int high = 0;
        for (int j = 0; j < 260; j++) begin
            cycle(j < 256, 1000, 0);
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL bypass_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (do_en === 1'b1) high++;
            if (j == 1) begin
                checks++;
                if (do_en !== 1'b0) begin failures++; $display("FAIL bypass_early_en got=%b want=0", do_en); end
            end
            if (j >= 2 && j <= 17) begin
                checks++;
                if (do_en !== 1'b1 || do_re !== 1000 || do_im !== 0) begin
                    failures++;
                    $display("FAIL bypass_exact j=%0d got en=%b re=%0d im=%0d want en=1 re=1000 im=0",
                             j, do_en, do_re, do_im);
                end
            end
        end
        checks++;
        if (high != 256) begin failures++; $display("FAIL bypass_en_len got=%0d want=256", high); end
    endtask

    task automatic test_unit_frame();
        for (int j = 0; j < 260; j++) begin
            cycle(j < 256, 16384, 0);
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL unit_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j == 19) begin
                checks++;
                if (do_re !== 16069 || do_im !== -3196) begin
                    failures++;
                    $display("FAIL unit_e2 got re=%0d im=%0d want re=16069 im=-3196", do_re, do_im);
                end
            end
        end
    endtask

    task automatic test_rotation_point();
        for (int j = 0; j < 68; j++) begin
            cycle(j < 64, (j == 52) ? 0 : rand16(), (j == 52) ? 16384 : rand16());
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL rot_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j == 54) begin
                checks++;
                if (do_re !== 15137 || do_im !== 6270) begin
                    failures++;
                    $display("FAIL rot_e12 got re=%0d im=%0d want re=15137 im=6270", do_re, do_im);
                end
            end
        end
    endtask

    task automatic test_saturation();
        for (int j = 0; j < 68; j++) begin
            cycle(j < 64, (j == 40) ? 32767 : rand16(), (j == 40) ? 32767 : rand16());
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL sat_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j == 42) begin
                checks++;
                if (do_re !== 32767 || do_im !== 0) begin
                    failures++;
                    $display("FAIL sat_e8 got re=%0d im=%0d want re=32767 im=0", do_re, do_im);
                end
            end
        end
    endtask

    task automatic test_gap();
        int ra = 0, rb = 0, a, b;
        for (int j = 0; j < 160; j++) begin
            a = rand16(); b = rand16();
            if (j == 102) begin ra = a; rb = b; end
            cycle((j != 100) && (j != 101) && (j < 156), a, b);
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL gap_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j >= 101 && j <= 104) begin
                checks++;
                if (do_en !== ((j == 101 || j == 104) ? 1'b1 : 1'b0)) begin
                    failures++;
                    $display("FAIL gap_en j=%0d got=%b want=%0d", j, do_en, (j == 101 || j == 104));
                end
            end
            if (j == 104) begin
                checks++;
                if (do_re !== ra || do_im !== rb) begin
                    failures++;
                    $display("FAIL gap_restart got re=%0d im=%0d want re=%0d im=%0d", do_re, do_im, ra, rb);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        int fa = 0, fb = 0, a, b;
        for (int j = 0; j < 20; j++) begin
            cycle(1'b1, rand16(), rand16());
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL prereset_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
        end
        di_en = 1'b1; di_re = WIDTH'(rand16()); di_im = WIDTH'(rand16());
        reset = 1'b1;
        #1;
        checks++;
        if (do_en !== 1'b0 || do_re !== 0 || do_im !== 0) begin
            failures++;
            $display("FAIL reset_async got en=%b re=%0d im=%0d want 0 0 0", do_en, do_re, do_im);
        end
        @(posedge clock);
        #1;
        checks++;
        if (do_en !== 1'b0 || do_re !== 0 || do_im !== 0) begin
            failures++;
            $display("FAIL reset_hold got en=%b re=%0d im=%0d want 0 0 0", do_en, do_re, do_im);
        end
        reset = 1'b0;
        reset_model();
        for (int j = 0; j < 24; j++) begin
            a = rand16(); b = rand16();
            if (j == 0) begin fa = a; fb = b; end
            cycle(j < 20, a, b);
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL postreset_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j < 2) begin
                checks++;
                if (do_en !== 1'b0 || do_re !== 0 || do_im !== 0) begin
                    failures++;
                    $display("FAIL reset_stale j=%0d got en=%b re=%0d im=%0d want 0 0 0", j, do_en, do_re, do_im);
                end
            end
            if (j == 2) begin
                checks++;
                if (do_en !== 1'b1 || do_re !== fa || do_im !== fb) begin
                    failures++;
                    $display("FAIL reset_index0 got en=%b re=%0d im=%0d want en=1 re=%0d im=%0d",
                             do_en, do_re, do_im, fa, fb);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        int wa = 0, wb = 0, a, b;
        for (int j = 0; j < 516; j++) begin
            a = rand16(); b = rand16();
            if (j == 256) begin wa = a; wb = b; end
            cycle(j < 512, a, b);
            checks++;
            if (do_en !== ex_en[0] || do_re !== ex_re || do_im !== ex_im) begin
                failures++;
                $display("FAIL b2b_stream j=%0d got en=%b re=%0d im=%0d want en=%0d re=%0d im=%0d",
                         j, do_en, do_re, do_im, ex_en, ex_re, ex_im);
            end
            if (j == 258) begin
                checks++;
                if (do_re !== wa || do_im !== wb) begin
                    failures++;
                    $display("FAIL b2b_wrap got re=%0d im=%0d want re=%0d im=%0d", do_re, do_im, wa, wb);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_bypass_frame();
        test_unit_frame();
        test_rotation_point();
        test_saturation();
        test_gap();
        test_mid_reset();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
